// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the datapath muxes it drives.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_WB_MEM   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_WB_R     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_EXEC_I   = 4'd11,
        S_WB_I     = 4'd12
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

    localparam logic [SEL_W-1:0] ALUB_REGB    = 2'b00;
    localparam logic [SEL_W-1:0] ALUB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] ALUB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic             pc_write;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_src;
        logic             instr_done;
        logic             illegal;
    } ctrl_t;

    // True when the opcode is supported and, for R-type, the function is too.
    function automatic logic instr_legal(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: ok = 1'b1;
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of the current state and live inputs into control outputs.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e          state,
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    input  logic            zero,
    input  logic            mem_ready,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUB_IMM_SH2;
                ctrl.illegal   = ~instr_legal(opcode, funct);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            // bne takes the branch on a nonzero compare, beq on zero.
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.pc_write   = (opcode == OP_BNE) ? ~zero : zero;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: steps each instruction through fetch/decode/execute/memory/write-back.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic [OP_W-1:0]    funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [SEL_W-1:0]   alu_src_b,
    output logic [SEL_W-1:0]   alu_op,
    output logic [SEL_W-1:0]   pc_src,
    output logic               instr_done,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    // Reset is asynchronous so write enables drop the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH;
                if (instr_legal(opcode, funct)) begin
                    case (opcode)
                        OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                        OP_RTYPE:       state_d = S_EXEC_R;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        OP_ADDI:        state_d = S_EXEC_I;
                        default:        state_d = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        pc_write   = ctrl.pc_write;
        iord       = ctrl.iord;
        mem_read   = ctrl.mem_read;
        mem_write  = ctrl.mem_write;
        ir_write   = ctrl.ir_write;
        reg_dst    = ctrl.reg_dst;
        mem_to_reg = ctrl.mem_to_reg;
        reg_write  = ctrl.reg_write;
        alu_src_a  = ctrl.alu_src_a;
        alu_src_b  = ctrl.alu_src_b;
        alu_op     = ctrl.alu_op;
        pc_src     = ctrl.pc_src;
        instr_done = ctrl.instr_done;
        illegal    = ctrl.illegal;
        state      = state_q;
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl against a per-instruction step model.
module tb_mc_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    mc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
        logic       mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       instr_done, illegal;
    } exp_t;

    typedef struct {
        int unsigned st;
        bit          mr;
    } step_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t observed();
        return exp_t'({pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
                       mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                       instr_done, illegal});
    endfunction

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        if (op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08}) return 1'b1;
        if (op == 6'h00) return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
        return 1'b0;
    endfunction

    // Output table by phase of the instruction, with live-input bits patched in.
    function automatic exp_t model_out(input int unsigned st, input bit mr, input bit z,
                                       input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        e = '0;
        case (st)
            1:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
            2:  begin e.alu_src_b = 2'b11; e.illegal = !legal(op, fn); end
            3:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4:  begin e.mem_read = 1; e.iord = 1; end
            5:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
            6:  begin e.mem_write = 1; e.iord = 1; e.instr_done = mr; end
            7:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            8:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
            9:  begin
                    e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.instr_done = 1;
                    e.pc_write = (op == 6'h05) ? !z : z;
                end
            10: begin e.pc_src = 2'b10; e.pc_write = 1; e.instr_done = 1; end
            11: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            12: begin e.reg_write = 1; e.instr_done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic step_t mk(input int unsigned s, input bit m);
        step_t t;
        t.st = s;
        t.mr = m;
        return t;
    endfunction

    // One instruction starting in FETCH; wf/wm are wait cycles, zf>1 means random zero.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input int zf);
        step_t q[$];
        int    dones;
        bit    ok;
        ok = legal(op, fn);
        for (int i = 0; i < wf; i++) q.push_back(mk(1, 1'b0));
        q.push_back(mk(1, 1'b1));
        q.push_back(mk(2, 1'($urandom)));
        if (ok) begin
            case (op)
                6'h23: begin
                    q.push_back(mk(3, 1'($urandom)));
                    for (int i = 0; i < wm; i++) q.push_back(mk(4, 1'b0));
                    q.push_back(mk(4, 1'b1));
                    q.push_back(mk(5, 1'($urandom)));
                end
                6'h2B: begin
                    q.push_back(mk(3, 1'($urandom)));
                    for (int i = 0; i < wm; i++) q.push_back(mk(6, 1'b0));
                    q.push_back(mk(6, 1'b1));
                end
                6'h00: begin q.push_back(mk(7, 1'($urandom))); q.push_back(mk(8, 1'($urandom))); end
                6'h08: begin q.push_back(mk(11, 1'($urandom))); q.push_back(mk(12, 1'($urandom))); end
                6'h04, 6'h05: q.push_back(mk(9, 1'($urandom)));
                default: q.push_back(mk(10, 1'($urandom)));
            endcase
        end
        dones = 0;
        foreach (q[k]) begin
            @(negedge clk);
            if (k == 0) begin
                opcode = op;
                funct  = fn;
            end
            mem_ready = q[k].mr;
            zero      = (zf > 1) ? 1'($urandom) : 1'(zf);
            #1;
            check($sformatf("%s state c%0d", name, k), 32'(state), 32'(q[k].st));
            check($sformatf("%s ctrl c%0d st%0d", name, k, q[k].st), 32'(observed()),
                  32'(model_out(q[k].st, q[k].mr, zero, op, fn)));
            dones += int'(instr_done);
        end
        check($sformatf("%s instr_done pulses", name), 32'(dones), ok ? 32'd1 : 32'd0);
    endtask

    logic [5:0] ops [8];
    logic [5:0] fns [5];

    initial begin
        logic [5:0] op, fn;
        int         r;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = 6'h23; funct = 6'h00;
        repeat (2) @(negedge clk);
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset ctrl", 32'(observed()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle state", 32'(state), 32'd0);
        check("idle ctrl", 32'(observed()), 32'd0);

        run_instr("lw",        6'h23, 6'h00, 0, 0, 2);
        run_instr("beq_taken", 6'h04, 6'h00, 0, 0, 1);
        run_instr("bne_z1",    6'h05, 6'h00, 0, 0, 1);
        run_instr("sw_wait3",  6'h2B, 6'h00, 0, 3, 2);
        run_instr("ill_op",    6'h3F, 6'h00, 0, 0, 2);
        run_instr("ill_funct", 6'h00, 6'h01, 0, 0, 2);
        run_instr("addi",      6'h08, 6'h00, 1, 0, 2);
        run_instr("j",         6'h02, 6'h00, 0, 0, 2);

        // Abort an R-type in write-back with an asynchronous reset.
        opcode = 6'h00; funct = 6'h20;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            check($sformatf("abort state c%0d", k), 32'(state), (k == 0) ? 32'd1 : (k == 1) ? 32'd2 : (k == 2) ? 32'd7 : 32'd8);
        end
        check("abort wb_r reg_write", 32'(reg_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort state", 32'(state), 32'd0);
        check("abort reg_write", 32'(reg_write), 32'd0);
        check("abort ctrl", 32'(observed()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort idle", 32'(state), 32'd0);

        for (int n = 0; n < 80; n++) begin
            r  = int'($urandom_range(0, 8));
            op = (r < 8) ? ops[r] : 6'($urandom);
            fn = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            run_instr($sformatf("rnd%0d op%0h", n, op), op, fn,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
